// File: rtl/wb32_to_wb8_bridge_if.sv
// Bus bundle for the 32-bit to 8-bit Wishbone width adapter.
// The bridge uses the slave view; the CPU/memory side (or a bench) uses the master view.
interface wb32_to_wb8_bridge_if #(
    parameter int ADDRBITS = 13
);
    logic                I_wb_stb;
    logic                I_wb_we;
    logic [3:0]          I_wb_sel;
    logic [ADDRBITS-3:0] I_wb_adr;
    logic [31:0]         I_wb_dat;
    logic [31:0]         O_wb_dat;
    logic                O_wb_ack;
    logic                O_mem_stb;
    logic                O_mem_we;
    logic [ADDRBITS-1:0] O_mem_adr;
    logic [7:0]          O_mem_dat;
    logic [7:0]          I_mem_dat;
    logic                I_mem_ack;

    modport slave (
        input  I_wb_stb, I_wb_we, I_wb_sel, I_wb_adr, I_wb_dat, I_mem_dat, I_mem_ack,
        output O_wb_dat, O_wb_ack, O_mem_stb, O_mem_we, O_mem_adr, O_mem_dat
    );

    modport master (
        output I_wb_stb, I_wb_we, I_wb_sel, I_wb_adr, I_wb_dat, I_mem_dat, I_mem_ack,
        input  O_wb_dat, O_wb_ack, O_mem_stb, O_mem_we, O_mem_adr, O_mem_dat
    );
endinterface

// File: rtl/wb32_to_wb8_bridge.sv
// Splits one 32-bit Wishbone access into ascending single-byte accesses on an 8-bit slave,
// assembling read bytes little-endian and returning a single acknowledge.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a 32-bit strobe; request latched when seen
// S_ISSUE | one-cycle byte strobe for the current lane
// S_WAIT  | byte access outstanding, waiting for the 8-bit acknowledge
// S_DONE  | one-cycle 32-bit acknowledge with the assembled word
module wb32_to_wb8_bridge #(
    parameter int ADDRBITS = 13
) (
    input logic                  I_wb_clk,
    input logic                  I_reset,
    wb32_to_wb8_bridge_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDRBITS-3:0] adr_q, adr_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [31:0]         rdat_q, rdat_d;
    logic                wb_ack_q, wb_ack_d;
    logic                mem_stb_q, mem_stb_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDRBITS-1:0] mem_adr_q, mem_adr_d;
    logic [7:0]          mem_dat_q, mem_dat_d;
    logic [3:0]          rem_sel;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] lanes_above(input logic [1:0] l);
        case (l)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        mem_we_d  = mem_we_q;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        rem_sel   = sel_q & lanes_above(lane_q);

        case (state_q)
            S_IDLE: begin
                if (bus.I_wb_stb) begin
                    we_d   = bus.I_wb_we;
                    sel_d  = bus.I_wb_sel;
                    adr_d  = bus.I_wb_adr;
                    wdat_d = bus.I_wb_dat;
                    rdat_d = '0;
                    if (bus.I_wb_sel != 4'b0000) begin
                        lane_d  = low_lane(bus.I_wb_sel);
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.I_mem_ack) begin
                    if (!we_q) rdat_d[{lane_q, 3'b000} +: 8] = bus.I_mem_dat;
                    if (rem_sel != 4'b0000) begin
                        lane_d  = low_lane(rem_sel);
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered against the next state so they line up with the state itself.
        mem_stb_d = (state_d == S_ISSUE);
        wb_ack_d  = (state_d == S_DONE);
        if (state_d == S_ISSUE) begin
            mem_adr_d = {adr_d, lane_d};
            mem_we_d  = we_d;
            mem_dat_d = wdat_d[{lane_d, 3'b000} +: 8];
        end
    end

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            state_q   <= S_IDLE;
            lane_q    <= 2'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'b0000;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            wb_ack_q  <= 1'b0;
            mem_stb_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            wb_ack_q  <= wb_ack_d;
            mem_stb_q <= mem_stb_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
        end
    end

    assign bus.O_wb_ack  = wb_ack_q;
    assign bus.O_wb_dat  = rdat_q;
    assign bus.O_mem_stb = mem_stb_q;
    assign bus.O_mem_we  = mem_we_q;
    assign bus.O_mem_adr = mem_adr_q;
    assign bus.O_mem_dat = mem_dat_q;

endmodule

// File: tb/tb_wb32_to_wb8_bridge.sv
// Scoreboard bench for wb32_to_wb8_bridge: directed test-plan cases plus random traffic,
// with a byte-array reference memory and an 8-bit slave model of configurable ack latency.
module tb_wb32_to_wb8_bridge;
    localparam int AB = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb32_to_wb8_bridge_if #(.ADDRBITS(AB)) bus ();
    wb32_to_wb8_bridge #(.ADDRBITS(AB)) dut (.I_wb_clk(clk), .I_reset(rst), .bus(bus));

    typedef struct {
        logic [31:0] dat;
        int          due;
    } wb_exp_t;
    typedef struct {
        logic [AB-1:0] adr;
        logic          we;
        logic [7:0]    dat;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];

    logic [7:0] smem [0:(1<<AB)-1];
    logic [7:0] rmem [0:(1<<AB)-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 1;
    int stb_seen = 0;
    bit spur_req = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s %s (t=%0t)", name, msg, $time);
    endtask

    // 8-bit slave: acks mem_lat cycles after seeing a strobe, checks every access in order.
    initial begin : mem_model
        int cnt;
        bit prev_stb;
        logic [7:0] pend;
        mem_exp_t e;
        cnt = -1;
        prev_stb = 1'b0;
        pend = 8'h00;
        bus.I_mem_ack = 1'b0;
        bus.I_mem_dat = 8'h00;
        forever begin
            @(negedge clk);
            bus.I_mem_ack = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.I_mem_ack = 1'b1;
                    bus.I_mem_dat = pend;
                    cnt = -1;
                end
            end
            if (spur_req) begin
                bus.I_mem_ack = 1'b1;
                bus.I_mem_dat = 8'hEE;
                spur_req = 1'b0;
            end
            if (bus.O_mem_stb === 1'b1) begin
                if (prev_stb) fail_now("mem_stb_width", "strobe high for more than one cycle");
                stb_seen++;
                if (mem_q.size() == 0) begin
                    fail_now("mem_unexpected", $sformatf("access adr=%0h we=%0b with none expected",
                             bus.O_mem_adr, bus.O_mem_we));
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_access", {bus.O_mem_adr, bus.O_mem_we, bus.O_mem_dat},
                        {e.adr, e.we, e.dat});
                end
                if (bus.O_mem_we) smem[bus.O_mem_adr] = bus.O_mem_dat;
                else pend = smem[bus.O_mem_adr];
                cnt = mem_lat;
            end
            prev_stb = (bus.O_mem_stb === 1'b1);
        end
    end

    // 32-bit side monitor: every acknowledge must match the next expected response.
    initial begin : wb_monitor
        wb_exp_t e;
        bit prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.O_wb_ack === 1'b1) begin
                if (prev_ack) fail_now("wb_ack_width", "acknowledge high for more than one cycle");
                if (wb_q.size() == 0) begin
                    fail_now("wb_unexpected", $sformatf("ack with dat=%0h and none expected", bus.O_wb_dat));
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_dat", bus.O_wb_dat, e.dat);
                    chk("wb_ack_cycle", cyc, e.due);
                end
            end
            prev_ack = (bus.O_wb_ack === 1'b1);
        end
    end

    // Called at a negedge with the bridge idle; returns at a negedge with the bridge idle.
    task automatic do_req(input logic we, input logic [3:0] sel, input logic [AB-3:0] adr,
                          input logic [31:0] dat, input int lat);
        int n;
        int t;
        logic [31:0] rd;
        logic [1:0] ln;
        logic [AB-1:0] a;
        mem_exp_t me;
        wb_exp_t we_e;
        n = 0;
        rd = 32'h0;
        mem_lat = lat;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                ln = i[1:0];
                a = {adr, ln};
                me.adr = a;
                me.we = we;
                me.dat = dat[8*i +: 8];
                mem_q.push_back(me);
                if (we) rmem[a] = dat[8*i +: 8];
                else rd[8*i +: 8] = rmem[a];
                n++;
            end
        end
        bus.I_wb_stb = 1'b1;
        bus.I_wb_we  = we;
        bus.I_wb_sel = sel;
        bus.I_wb_adr = adr;
        bus.I_wb_dat = dat;
        @(posedge clk);
        #1;
        we_e.dat = we ? 32'h0 : rd;
        we_e.due = cyc + n * (1 + lat);
        wb_q.push_back(we_e);
        bus.I_wb_we  = $urandom_range(0, 1);
        bus.I_wb_sel = 4'($urandom);
        bus.I_wb_adr = (AB-2)'($urandom);
        bus.I_wb_dat = $urandom;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.O_wb_ack !== 1'b1 && t < 400);
        if (t >= 400) begin
            fail_now("wb_timeout", "no acknowledge within 400 cycles");
            wb_q.delete();
            mem_q.delete();
        end
        bus.I_wb_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wb_ack"},  bus.O_wb_ack, 1'b0);
        chk({tag, "_wb_dat"},  bus.O_wb_dat, 32'h0);
        chk({tag, "_mem_stb"}, bus.O_mem_stb, 1'b0);
        chk({tag, "_mem_we"},  bus.O_mem_we, 1'b0);
        chk({tag, "_mem_adr"}, bus.O_mem_adr, '0);
        chk({tag, "_mem_dat"}, bus.O_mem_dat, 8'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b;
        int base;
        int t;
        int bad;
        bus.I_wb_stb = 1'b0;
        bus.I_wb_we  = 1'b0;
        bus.I_wb_sel = 4'h0;
        bus.I_wb_adr = '0;
        bus.I_wb_dat = 32'h0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            smem[i] = b;
            rmem[i] = b;
        end
        smem[0] = 8'h11; rmem[0] = 8'h11;
        smem[1] = 8'h22; rmem[1] = 8'h22;
        smem[2] = 8'h33; rmem[2] = 8'h33;
        smem[3] = 8'h44; rmem[3] = 8'h44;
        smem[9] = 8'h5A; rmem[9] = 8'h5A;
        smem[11] = 8'hA5; rmem[11] = 8'hA5;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 4'b1111, 11'd0, 32'h0, 1);
        do_req(1'b1, 4'b0100, 11'd1, 32'hAABBCCDD, 1);
        do_req(1'b0, 4'b1111, 11'd1, 32'h0, 1);
        do_req(1'b0, 4'b1010, 11'd2, 32'h0, 1);
        do_req(1'b0, 4'b0000, 11'd3, 32'h12345678, 1);
        do_req(1'b1, 4'b0000, 11'd3, 32'h12345678, 1);

        spur_req = 1'b1;
        repeat (2) @(negedge clk);
        do_req(1'b0, 4'b1111, 11'd0, 32'h0, 3);

        // Abort a word read while lane 1 is outstanding; its late ack must be ignored.
        mem_lat = 3;
        base = stb_seen;
        for (int i = 0; i < 2; i++) begin
            mem_exp_t me;
            logic [1:0] ln;
            ln = i[1:0];
            me.adr = {11'd5, ln};
            me.we = 1'b0;
            me.dat = 8'h00;
            mem_q.push_back(me);
        end
        bus.I_wb_stb = 1'b1;
        bus.I_wb_we  = 1'b0;
        bus.I_wb_sel = 4'b1111;
        bus.I_wb_adr = 11'd5;
        bus.I_wb_dat = 32'h0;
        t = 0;
        while (stb_seen < base + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("abort_setup", "second lane strobe never seen");
        @(negedge clk);
        rst = 1'b1;
        bus.I_wb_stb = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_mem_q_empty", mem_q.size(), 0);

        do_req(1'b0, 4'b1111, 11'd0, 32'h0, 1);

        for (int k = 0; k < 40; k++) begin
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   11'($urandom_range(0, 63)), $urandom, $urandom_range(1, 3));
        end

        repeat (8) @(negedge clk);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (smem[i] !== rmem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
